// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Load/store initiator sitting between the Mem pipeline stage and a word-wide
// data memory (synchronous write, asynchronous read, indexed by addr[12:2]).
//
//   * Word, halfword and byte loads complete combinationally. The selected
//     little-endian lane is sign- or zero-extended.
//   * Aligned word stores write at the current edge.
//   * Sub-word stores use a two-cycle read-modify-write. The first cycle stalls
//     the pipeline and captures the old word. The second cycle writes the
//     merged word.
//   * Misaligned requests are flagged, suppressed and counted. The counter
//     saturates.
//
// Ports
//   clk, rst       rising-edge clock, synchronous active-high reset
//   Mem_ALUout     effective byte address
//   Mem_datain     store data (low byte/half used for sub-word stores)
//   Mem_MemRd      load request
//   Mem_MemWr      store request (wins if both requests are asserted)
//   Mem_Size       00 byte, 01 half, 10/11 word
//   Mem_Unsigned   1 = zero-extend load, 0 = sign-extend load
//   Mem_Do         extended load result
//   Mem_Stall      freeze the upstream pipeline this cycle
//   Mem_AddrErr    current request is misaligned
//   Mem_ErrCnt     saturating count of misaligned requests
//   dm_addr        data memory address
//   dm_wdata       data memory write data
//   dm_we          data memory write enable
//   dm_rdata       data memory asynchronous read data
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          Mem_ALUout,
    input  logic [31:0]          Mem_datain,
    input  logic                 Mem_MemRd,
    input  logic                 Mem_MemWr,
    input  logic [1:0]           Mem_Size,
    input  logic                 Mem_Unsigned,
    output logic [31:0]          Mem_Do,
    output logic                 Mem_Stall,
    output logic                 Mem_AddrErr,
    output logic [ERR_CNT_W-1:0] Mem_ErrCnt,
    output logic [31:0]          dm_addr,
    output logic [31:0]          dm_wdata,
    output logic                 dm_we,
    input  logic [31:0]          dm_rdata
);

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    state_t                 state, state_next;
    logic [31:0]            hold_addr;
    logic [31:0]            hold_word;
    logic [15:0]            hold_data;
    logic [1:0]             hold_size;
    logic [ERR_CNT_W-1:0]   err_cnt;

    logic                   is_byte, is_half, is_word;
    logic                   misaligned;
    logic                   addr_err;
    logic                   rmw_start;
    logic [7:0]             ld_byte;
    logic [15:0]            ld_half;
    logic [31:0]            ld_value;
    logic [31:0]            lane_mask;
    logic [31:0]            lane_data;
    logic [31:0]            merged_word;

    // Request decode. Size 11 is reserved and behaves as a word access.
    assign is_byte = (Mem_Size == SIZE_BYTE);
    assign is_half = (Mem_Size == SIZE_HALF);
    assign is_word = !is_byte && !is_half;

    assign misaligned = (is_half && Mem_ALUout[0]) ||
                        (is_word && (Mem_ALUout[1:0] != 2'b00));

    // Alignment is only judged in IDLE. In RMW_WR the inputs still show the
    // instruction that was already accepted.
    assign addr_err  = (state == IDLE) && (Mem_MemRd || Mem_MemWr) && misaligned;
    assign rmw_start = (state == IDLE) && Mem_MemWr && !misaligned && !is_word;

    // Load lane selection, little-endian.
    always_comb begin
        case (Mem_ALUout[1:0])
            2'd0:    ld_byte = dm_rdata[7:0];
            2'd1:    ld_byte = dm_rdata[15:8];
            2'd2:    ld_byte = dm_rdata[23:16];
            default: ld_byte = dm_rdata[31:24];
        endcase
        ld_half = Mem_ALUout[1] ? dm_rdata[31:16] : dm_rdata[15:0];

        if (is_byte) begin
            ld_value = {{24{!Mem_Unsigned && ld_byte[7]}}, ld_byte};
        end else if (is_half) begin
            ld_value = {{16{!Mem_Unsigned && ld_half[15]}}, ld_half};
        end else begin
            ld_value = dm_rdata;
        end
    end

    // RMW merge. Replicate the new data across all lanes, then keep only the
    // target lane of it.
    always_comb begin
        if (hold_size == SIZE_BYTE) begin
            lane_mask = 32'h0000_00FF << {hold_addr[1:0], 3'b000};
            lane_data = {4{hold_data[7:0]}};
        end else begin
            lane_mask = 32'h0000_FFFF << {hold_addr[1], 4'b0000};
            lane_data = {2{hold_data}};
        end
        merged_word = (hold_word & ~lane_mask) | (lane_data & lane_mask);
    end

    // Next-state and output logic.
    // NOTE: every output gets a default before any branch. A path that leaves
    // a signal unassigned in always_comb would infer a latch.
    always_comb begin
        state_next  = state;
        Mem_Do      = 32'h0;
        Mem_Stall   = 1'b0;
        Mem_AddrErr = 1'b0;
        dm_addr     = Mem_ALUout;
        dm_wdata    = Mem_datain;
        dm_we       = 1'b0;

        case (state)
            IDLE: begin
                if (addr_err) begin
                    Mem_AddrErr = 1'b1;
                end else if (Mem_MemWr) begin
                    if (is_word) begin
                        dm_we = 1'b1;
                    end else begin
                        Mem_Stall  = 1'b1;
                        state_next = RMW_WR;
                    end
                end else if (Mem_MemRd) begin
                    Mem_Do = ld_value;
                end
            end
            RMW_WR: begin
                dm_addr    = hold_addr;
                dm_wdata   = merged_word;
                dm_we      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // No write may reach the memory while reset is asserted.
        if (rst) begin
            dm_we = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold_addr <= 32'h0;
            hold_word <= 32'h0;
            hold_data <= 16'h0;
            hold_size <= 2'b00;
            err_cnt   <= '0;
        end else begin
            state <= state_next;
            if (rmw_start) begin
                hold_addr <= Mem_ALUout;
                hold_word <= dm_rdata;
                hold_data <= Mem_datain[15:0];
                hold_size <= Mem_Size;
            end
            if (addr_err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end
    end

    assign Mem_ErrCnt = err_cnt;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store initiator between the Mem pipeline stage and the word-wide data memory. The data memory has a synchronous write and an asynchronous read, and is indexed by addr[12:2].
- Handles word, halfword and byte loads (sign- or zero-extended) and stores.
- Sub-word stores are done as a two-cycle read-modify-write (RMW). The pipeline is stalled for one cycle during the RMW.
- Misaligned accesses are detected, suppressed and counted.

Parameters:
- ERR_CNT_W, 8, width of the saturating misalignment error counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- Mem_ALUout  in  32  effective byte address.
- Mem_datain  in  32  store data (rt); the low byte/half is used for sub-word stores.
- Mem_MemRd  in  1  load request.
- Mem_MemWr  in  1  store request.
- Mem_Size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- Mem_Unsigned  in  1  1 = zero-extend a load, 0 = sign-extend a load.
- Mem_Do  out  32  extended load result.
- Mem_Stall  out  1  freeze the pipeline (PC, IF/ID, ID/EX, EX/MEM) this cycle.
- Mem_AddrErr  out  1  the current request is misaligned.
- Mem_ErrCnt  out  ERR_CNT_W  saturating count of misaligned requests.
- dm_addr  out  32  address to the data memory.
- dm_wdata  out  32  write data to the data memory.
- dm_we  out  1  write enable to the data memory.
- dm_rdata  in  32  asynchronous read data from the data memory.

Behaviour:
- Byte lanes are little-endian.
  - Byte k is dm_rdata[8k+7:8k], with k = addr[1:0].
  - Half h is dm_rdata[16h+15:16h], with h = addr[1].
- Alignment rules:
  - Half is misaligned if addr[0] = 1.
  - Word is misaligned if addr[1:0] != 0.
  - Byte is never misaligned.
- FSM states: IDLE, RMW_WR.
- Reset:
  - state = IDLE; Mem_ErrCnt = 0.
  - Registered hold_addr, hold_word, hold_data and hold_size are cleared to 0.
  - dm_we = 0 whenever state = IDLE and no aligned word store is present.
- IDLE, no request: dm_we = 0; Mem_Stall = 0; Mem_Do = 0; dm_addr = Mem_ALUout.
- IDLE, load:
  - Mem_Do is combinational from dm_rdata: the selected lane, extended per Mem_Unsigned.
  - A word load is passed through unchanged.
  - Latency is 0 cycles; no stall.
- IDLE, aligned word store: dm_we = 1; dm_wdata = Mem_datain; the write happens at this edge; no stall.
- IDLE, aligned sub-word store:
  - Mem_Stall = 1 and dm_we = 0.
  - At the edge, capture hold_word = dm_rdata, and latch hold_addr, hold_data and hold_size from the request.
  - Next state = RMW_WR.
- RMW_WR:
  - dm_addr = hold_addr; dm_we = 1.
  - dm_wdata = hold_word with the target lane replaced by hold_data[7:0] (byte) or hold_data[15:0] (half).
  - Mem_Stall = 0, so the pipeline advances at the same edge the write lands.
  - Next state = IDLE unconditionally. Inputs are ignored in this cycle: they still present the same, already-latched instruction.
- Misaligned request (load or store):
  - Mem_AddrErr = 1; dm_we = 0; Mem_Do = 0; no stall.
  - Mem_ErrCnt increments at the edge and saturates at all-ones.
  - Misalignment is checked only in IDLE.
- Mem_MemRd and Mem_MemWr both asserted: the store is performed; Mem_Do = 0.
- Reset during RMW_WR: the write is suppressed (dm_we = 0 while rst = 1); state returns to IDLE and the hold registers are cleared.
- Back-to-back sub-word stores: each costs exactly one stall cycle. A load directly after an RMW write sees the updated word (write at edge, asynchronous read next cycle).

Test Plan:
- Word store then word load:
  - Store 0xDEADBEEF to address 0x10 -> dm_we = 1 for 1 cycle, no stall.
  - Load word from 0x10 -> Mem_Do = 0xDEADBEEF.
- Byte store into a word holding 0x11223344:
  - sb 0xAB to address 0x11 -> Mem_Stall = 1 for exactly 1 cycle, then dm_we = 1 with dm_wdata = 0x1122AB44.
  - A following lw returns 0x1122AB44.
- Signed/unsigned half loads from word 0x80017FFF:
  - lh at 0x2 -> 0xFFFF8001; lhu at 0x2 -> 0x00008001.
  - lb at 0x0 -> 0xFFFFFFFF; lbu at 0x1 -> 0x0000007F.
- Misaligned accesses:
  - sh to 0x13 -> Mem_AddrErr = 1, dm_we never 1, memory unchanged.
  - lw from 0x12 -> Mem_Do = 0.
  - After 300 misaligned requests, Mem_ErrCnt = 255.
- Reset during RMW: assert rst in the RMW_WR cycle -> no write occurs, the target word is unchanged, and state = IDLE next cycle.
- Back-to-back stores sb 0x01 @0x20 then sh 0xBEEF @0x22 on a word holding 0 -> two stall cycles total; final word = 0xBEEF0001.
